enemy_shot_scheduler: RTL and testbench

- Upstream feeder of the projectiles top block: decides, once per video frame, which enemy bikes fire.
- Drives the per-enemy one-cycle shoot-request vector consumed by the enemy projectile slots.
- Decisions combine per-enemy frame cooldowns, projectile-busy feedback, an LFSR random draw, a level-scaled fire probability, and a horizontal aim bias toward the player.

---
 rtl/projectiles_pkg.sv | 41 ++++
 rtl/shot_lfsr16.sv | 30 +++
 rtl/enemy_shot_scheduler.sv | 143 ++++++++++++++
 tb/tb_enemy_shot_scheduler.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/projectiles_pkg.sv
// Shared types, constants and saturating helpers for the enemy shot scheduler.
// Imported by the scheduler top and its LFSR.
package projectiles_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } sched_state_t;

  localparam int ENEMY_BIKES_COUNT   = 8;
  localparam int MAX_SHOTS_PER_FRAME = 2;

  localparam logic [7:0]  BASE_COOLDOWN = 8'd90;
  localparam logic [7:0]  COOLDOWN_STEP = 8'd6;
  localparam logic [7:0]  MIN_COOLDOWN  = 8'd20;
  localparam logic [7:0]  BASE_THRESH   = 8'd32;
  localparam logic [7:0]  THRESH_STEP   = 8'd16;
  localparam logic [10:0] AIM_WINDOW    = 11'd64;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [7:0] sat_sub(
    input logic [7:0] a,
    input logic [7:0] b
  );
    return (a > b) ? (a - b) : 8'd0;
  endfunction

  function automatic logic [7:0] sat_add(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/shot_lfsr16.sv
// Free-running 16-bit Galois LFSR used as the per-cycle fire draw.
// Nonzero seed keeps it off the all-zero lockup state.
module shot_lfsr16
  import projectiles_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        en,
  output logic [15:0] out
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/enemy_shot_scheduler.sv
// Once-per-frame round-robin scan deciding which enemy bikes fire,
// issuing one-cycle shoot pulses to the enemy projectile slots.
module enemy_shot_scheduler
  import projectiles_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 resetN,
  input  logic                                 startOfFrame,
  input  logic [3:0]                           level,
  input  logic                                 endLevel,
  input  logic [ENEMY_BIKES_COUNT-1:0]         enemyAlive,
  input  logic [ENEMY_BIKES_COUNT-1:0]         projectileBusy,
  input  logic [10:0]                          playerX,
  input  logic [ENEMY_BIKES_COUNT-1:0][10:0]   enemyXVector,
  output logic [ENEMY_BIKES_COUNT-1:0]         shootRequestEnemy,
  output logic                                 scanActive
);

  localparam int N  = ENEMY_BIKES_COUNT;
  localparam int IW = $clog2(N);
  localparam int SW = $clog2(MAX_SHOTS_PER_FRAME + 1);
  localparam logic [IW-1:0] LAST     = IW'(N - 1);
  localparam logic [IW:0]   N_W      = (IW + 1)'(N);
  localparam logic [SW-1:0] SHOT_CAP = SW'(MAX_SHOTS_PER_FRAME);

  sched_state_t  state_q, state_d;
  logic [IW-1:0] k_q, k_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [SW-1:0] shots_q, shots_d;
  logic [N-1:0]  req_q, req_d;
  logic [7:0]    cd_q [N];
  logic [7:0]    cd_d [N];

  logic [15:0] lfsr;
  logic        lfsr_unused;

  shot_lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .resetN(resetN),
    .en    (1'b1),
    .out   (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:8];

  logic [7:0]  cd_step;
  logic [7:0]  reload;
  logic [8:0]  thr_sum;
  logic [7:0]  thresh;
  logic [IW:0] j_sum;
  logic [IW-1:0] j;
  logic [10:0] dx;
  logic [7:0]  eff_thresh;
  logic        eligible;
  logic        fire;

  always_comb begin
    cd_step = 8'(level) * COOLDOWN_STEP;
    reload  = sat_sub(BASE_COOLDOWN, cd_step);
    if (reload < MIN_COOLDOWN) reload = MIN_COOLDOWN;

    thr_sum = 9'(BASE_THRESH) + 9'(level) * 9'(THRESH_STEP);
    thresh  = thr_sum[8] ? 8'hFF : thr_sum[7:0];

    j_sum = {1'b0, rr_q} + {1'b0, k_q};
    j     = (j_sum >= N_W) ? IW'(j_sum - N_W) : j_sum[IW-1:0];

    dx = (enemyXVector[j] >= playerX) ? (enemyXVector[j] - playerX)
                                      : (playerX - enemyXVector[j]);
    eff_thresh = (dx <= AIM_WINDOW) ? sat_add(thresh, thresh) : thresh;

    eligible = enemyAlive[j] && !projectileBusy[j] &&
               (cd_q[j] == 8'd0) && (shots_q < SHOT_CAP);
    fire = eligible && (lfsr[7:0] <= eff_thresh);
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rr_d    = rr_q;
    shots_d = shots_q;
    req_d   = '0;
    for (int i = 0; i < N; i++) cd_d[i] = cd_q[i];

    if (endLevel) begin
      state_d = HOLD;
      for (int i = 0; i < N; i++) cd_d[i] = 8'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (startOfFrame) begin
            state_d = SCAN;
            k_d     = '0;
            shots_d = '0;
            for (int i = 0; i < N; i++) begin
              if (cd_q[i] != 8'd0) cd_d[i] = cd_q[i] - 8'd1;
            end
          end
        end
        SCAN: begin
          if (fire) begin
            req_d[j] = 1'b1;
            cd_d[j]  = reload;
            shots_d  = shots_q + 1'b1;
          end
          if (k_q == LAST) begin
            k_d     = '0;
            rr_d    = (rr_q == LAST) ? '0 : rr_q + 1'b1;
            state_d = IDLE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        HOLD: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q <= IDLE;
      k_q     <= '0;
      rr_q    <= '0;
      shots_q <= '0;
      req_q   <= '0;
      for (int i = 0; i < N; i++) cd_q[i] <= 8'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rr_q    <= rr_d;
      shots_q <= shots_d;
      req_q   <= req_d;
      for (int i = 0; i < N; i++) cd_q[i] <= cd_d[i];
    end
  end

  assign shootRequestEnemy = req_q;
  assign scanActive        = (state_q == SCAN);

endmodule

// File: tb/tb_enemy_shot_scheduler.sv
// Randomised bench for enemy_shot_scheduler against a frame-level
// reference model of the firing rules.
module tb_enemy_shot_scheduler;
  import projectiles_pkg::*;

  localparam int N = ENEMY_BIKES_COUNT;

  logic clk = 1'b0;
  logic resetN, sof, endl, sa;
  logic [3:0] level;
  logic [N-1:0] alive, busy, shoot;
  logic [10:0] px;
  logic [N-1:0][10:0] exv;

  always #5 clk = ~clk;

  enemy_shot_scheduler dut (
    .clk              (clk),
    .resetN           (resetN),
    .startOfFrame     (sof),
    .level            (level),
    .endLevel         (endl),
    .enemyAlive       (alive),
    .projectileBusy   (busy),
    .playerX          (px),
    .enemyXVector     (exv),
    .shootRequestEnemy(shoot),
    .scanActive       (sa)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int m_cd [N];
  int m_rr;
  logic [15:0] m_lfsr;

  logic [N-1:0] fr_obs [N];
  logic [N-1:0] fr_exp [N];
  logic fr_sa_all, fr_sa_end;
  int fr_fired;
  bit sof_in_scan = 1'b0;
  logic [N-1:0] gap_or;
  logic gap_sa;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  always @(posedge clk) m_lfsr <= resetN ? 16'hACE1 : lfsr_next(m_lfsr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_cd[i] = 0;
  endtask

  task automatic gap(input int n);
    gap_or = '0;
    gap_sa = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      gap_or |= shoot;
      gap_sa |= sa;
    end
  endtask

  task automatic clear_cd();
    endl = 1'b1;
    tick();
    endl = 1'b0;
    tick();
    model_clear();
  endtask

  // Frame start plus ncyc scan cycles; fills fr_obs / fr_exp.
  task automatic run_frame(input int ncyc);
    int j, rl, th, eff, d;
    sof = 1'b1;
    tick();
    sof = sof_in_scan;
    for (int i = 0; i < N; i++) if (m_cd[i] > 0) m_cd[i]--;
    rl = 90 - 6 * int'(level);
    if (rl < 20) rl = 20;
    th = 32 + 16 * int'(level);
    if (th > 255) th = 255;
    fr_fired = 0;
    fr_sa_all = 1'b1;
    for (int k = 0; k < N; k++) begin
      fr_obs[k] = '0;
      fr_exp[k] = '0;
    end
    for (int k = 0; k < ncyc; k++) begin
      fr_sa_all &= sa;
      j = (m_rr + k) % N;
      d = int'(exv[j]) - int'(px);
      if (d < 0) d = -d;
      eff = (d <= 64) ? ((2 * th > 255) ? 255 : 2 * th) : th;
      if (alive[j] && !busy[j] && m_cd[j] == 0 && fr_fired < 2 &&
          int'(m_lfsr[7:0]) <= eff) begin
        fr_exp[k][j] = 1'b1;
        m_cd[j] = rl;
        fr_fired++;
      end
      tick();
      fr_obs[k] = shoot;
    end
    sof = 1'b0;
    fr_sa_end = sa;
    if (ncyc == N) m_rr = (m_rr + 1) % N;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (shoot !== '0 || sa !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: shoot=%b sa=%b want 0/0", shoot, sa);
    end
    level = 4'd15;
    alive = '1;
    busy = '0;
    sof = 1'b1;
    tick();
    sof = 1'b0;
    tick();
    tick();
    resetN = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (shoot !== '0 || sa !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid_scan: shoot=%b sa=%b want 0/0", shoot, sa);
      end
      n_cmp++;
      if (dut.u_lfsr.out !== 16'hACE1) begin
        n_bad++;
        $display("FAIL reset_lfsr: got %h want ace1", dut.u_lfsr.out);
      end
    end
    resetN = 1'b0;
    model_clear();
    m_rr = 0;
    gap(3);
    n_cmp++;
    if (gap_or !== '0 || gap_sa !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: pulses=%b sa=%b want 0/0", gap_or, gap_sa);
    end
  endtask

  task automatic test_forced_fire();
    level = 4'd15;
    alive = 8'h01;
    busy = '0;
    px = 11'd100;
    for (int i = 0; i < N; i++) exv[i] = 11'd1000;
    run_frame(N);
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (fr_obs[k] !== fr_exp[k]) begin
        n_bad++;
        $display("FAIL forced_pulse k=%0d: got %b want %b", k, fr_obs[k], fr_exp[k]);
      end
    end
    n_cmp++;
    if (fr_fired !== 1 || fr_sa_all !== 1'b1 || fr_sa_end !== 1'b0) begin
      n_bad++;
      $display("FAIL forced_count: fired=%0d sa=%b/%b want 1 1/0",
               fr_fired, fr_sa_all, fr_sa_end);
    end
    n_cmp++;
    if (dut.cd_q[0] !== 8'd20) begin
      n_bad++;
      $display("FAIL forced_cooldown: got %0d want 20", dut.cd_q[0]);
    end
  endtask

  task automatic test_cooldown();
    int early, total, got;
    early = 0;
    total = 0;
    for (int f = 1; f <= 25; f++) begin
      gap($urandom_range(0, 2));
      run_frame(N);
      got = 0;
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if (fr_obs[k] !== fr_exp[k]) begin
          n_bad++;
          $display("FAIL cooldown_pulse f=%0d k=%0d: got %b want %b",
                   f, k, fr_obs[k], fr_exp[k]);
        end
        got += $countones(fr_obs[k]);
      end
      total += got;
      if (f <= 19) early += got;
    end
    n_cmp++;
    if (early !== 0 || total !== 1) begin
      n_bad++;
      $display("FAIL cooldown_window: early=%0d total=%0d want 0/1", early, total);
    end
  endtask

  task automatic test_sof_during_scan();
    clear_cd();
    run_frame(N);
    sof_in_scan = 1'b1;
    run_frame(N);
    sof_in_scan = 1'b0;
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (fr_obs[k] !== fr_exp[k]) begin
        n_bad++;
        $display("FAIL sof_scan_pulse k=%0d: got %b want %b", k, fr_obs[k], fr_exp[k]);
      end
    end
    n_cmp++;
    if (dut.cd_q[0] !== 8'd19) begin
      n_bad++;
      $display("FAIL sof_scan_cooldown: got %0d want 19", dut.cd_q[0]);
    end
  endtask

  task automatic test_busy_cap();
    logic [N-1:0] acc;
    level = 4'd15;
    alive = '1;
    busy = 8'h0F;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < N; i++) exv[i] = px + 11'($urandom_range(0, 140)) - 11'd70;
      clear_cd();
      run_frame(N);
      acc = '0;
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if (fr_obs[k] !== fr_exp[k]) begin
          n_bad++;
          $display("FAIL cap_pulse f=%0d k=%0d: got %b want %b",
                   f, k, fr_obs[k], fr_exp[k]);
        end
        acc |= fr_obs[k];
      end
      n_cmp++;
      if ($countones(acc) !== 2 || (acc & 8'h0F) !== '0) begin
        n_bad++;
        $display("FAIL cap_count f=%0d: pulses=%b want two bits within f0", f, acc);
      end
    end
    busy = '0;
  endtask

  task automatic test_aim_bias();
    int near_cnt, far_cnt;
    near_cnt = 0;
    far_cnt = 0;
    level = 4'd0;
    alive = 8'h03;
    busy = '0;
    for (int f = 0; f < 3000; f++) begin
      px = 11'($urandom_range(400, 1600));
      exv[0] = $urandom_range(0, 1) ? px + 11'd10 : px - 11'd10;
      exv[1] = $urandom_range(0, 1) ? px + 11'd300 : px - 11'd300;
      clear_cd();
      gap($urandom_range(0, 3));
      run_frame(N);
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if (fr_obs[k] !== fr_exp[k]) begin
          n_bad++;
          $display("FAIL aim_pulse f=%0d k=%0d: got %b want %b",
                   f, k, fr_obs[k], fr_exp[k]);
        end
        near_cnt += int'(fr_obs[k][0]);
        far_cnt += int'(fr_obs[k][1]);
      end
    end
    n_cmp++;
    if (!(near_cnt * 100 >= far_cnt * 170 && near_cnt * 100 <= far_cnt * 230)) begin
      n_bad++;
      $display("FAIL aim_ratio: near=%0d far=%0d want ratio 1.7..2.3", near_cnt, far_cnt);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 200; f++) begin
      level = 4'($urandom_range(0, 15));
      alive = 8'($urandom);
      busy = 8'($urandom);
      px = 11'($urandom_range(100, 1900));
      for (int i = 0; i < N; i++) exv[i] = px + 11'($urandom_range(0, 160)) - 11'd80;
      if ($urandom_range(0, 9) == 0) clear_cd();
      gap($urandom_range(0, 2));
      run_frame(N);
      for (int k = 0; k < N; k++) begin
        n_cmp++;
        if (fr_obs[k] !== fr_exp[k]) begin
          n_bad++;
          $display("FAIL random_pulse f=%0d k=%0d: got %b want %b",
                   f, k, fr_obs[k], fr_exp[k]);
        end
      end
    end
  endtask

  task automatic test_end_level();
    logic [N-1:0] acc;
    level = 4'd15;
    alive = '1;
    busy = '0;
    clear_cd();
    run_frame(2);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (fr_obs[k] !== fr_exp[k]) begin
        n_bad++;
        $display("FAIL endlvl_pre k=%0d: got %b want %b", k, fr_obs[k], fr_exp[k]);
      end
    end
    endl = 1'b1;
    tick();
    model_clear();
    n_cmp++;
    if (shoot !== '0 || sa !== 1'b0) begin
      n_bad++;
      $display("FAIL endlvl_abort: shoot=%b sa=%b want 0/0", shoot, sa);
    end
    acc = '0;
    for (int f = 0; f < 3; f++) begin
      sof = 1'b1;
      tick();
      sof = 1'b0;
      acc |= shoot;
      gap(9);
      acc |= gap_or;
    end
    n_cmp++;
    if (acc !== '0) begin
      n_bad++;
      $display("FAIL endlvl_hold_pulses: got %b want 0", acc);
    end
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (dut.cd_q[i] !== 8'd0) begin
        n_bad++;
        $display("FAIL endlvl_cooldown i=%0d: got %0d want 0", i, dut.cd_q[i]);
      end
    end
    endl = 1'b0;
    sof = 1'b1;
    tick();
    sof = 1'b0;
    gap(4);
    n_cmp++;
    if (gap_or !== '0 || gap_sa !== 1'b0) begin
      n_bad++;
      $display("FAIL endlvl_release: pulses=%b sa=%b want 0/0", gap_or, gap_sa);
    end
    run_frame(N);
    for (int k = 0; k < N; k++) begin
      n_cmp++;
      if (fr_obs[k] !== fr_exp[k]) begin
        n_bad++;
        $display("FAIL endlvl_resume k=%0d: got %b want %b", k, fr_obs[k], fr_exp[k]);
      end
    end
    n_cmp++;
    if (fr_fired !== 2) begin
      n_bad++;
      $display("FAIL endlvl_resume_count: got %0d want 2", fr_fired);
    end
  endtask

  initial begin
    resetN = 1'b1;
    sof = 1'b0;
    endl = 1'b0;
    level = '0;
    alive = '0;
    busy = '0;
    px = 11'd500;
    for (int i = 0; i < N; i++) exv[i] = 11'd0;
    model_clear();
    m_rr = 0;
    tick();
    tick();
    resetN = 1'b0;
    test_reset();
    test_forced_fire();
    test_cooldown();
    test_sof_during_scan();
    test_busy_cap();
    test_aim_bias();
    test_random();
    test_end_level();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
